// File: rtl/block_ram_rtl_pkg.sv
// Shared types and default widths for the block RAM request controller.
package block_ram_rtl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } transaction_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/block_ram_cmd_fifo.sv
// In-order request queue; DEPTH must be a power of two. A push while full is
// dropped even if a pop happens in the same cycle (no bypass).
module block_ram_cmd_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/block_ram_req_ctrl.sv
// Queues RAM read/write requests and sequences them onto a single RAM port.
// Define BLOCK_RAM_WR_ACK_EN to make every write return a response as well.
//
// state   | meaning
// IDLE    | RAM idle, waiting for a queued request
// ACCESS  | ram_* driven for one access (back-to-back writes stay here)
// RD_WAIT | RAM read data arriving, captured into the response
// RESP    | response held until rsp_ready
module block_ram_req_ctrl
  import block_ram_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr
);

`ifdef BLOCK_RAM_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  state_t                state, state_nxt;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0]    head;
  transaction_type       head_type;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  logic                  ram_en_nxt, ram_we_nxt, rsp_valid_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt, rsp_addr_nxt;
  logic [DATA_WIDTH-1:0] ram_wdata_nxt, rsp_rdata_nxt;

  assign req_ready  = !fifo_full && !rst;
  assign push       = req_valid && req_ready;
  assign head_type  = transaction_type'(head[ENTRY_W-1]);
  assign head_addr  = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign head_wdata = head[DATA_WIDTH-1:0];

  block_ram_cmd_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({req_type, req_addr, req_wdata}),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      state     <= state_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_addr  <= rsp_addr_nxt;
    end
  end

  // In ACCESS, ram_we tells whether the access in flight is a write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = ACCESS;
      ACCESS: begin
        if (!ram_we)          state_nxt = RD_WAIT;
        else if (WR_ACK)      state_nxt = RESP;
        else if (fifo_empty)  state_nxt = IDLE;
      end
      RD_WAIT: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop           = 1'b0;
    ram_en_nxt    = ram_en;
    ram_we_nxt    = ram_we;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_addr_nxt  = rsp_addr;
    unique case (state)
      IDLE, ACCESS: begin
        if (state == ACCESS && ram_we && WR_ACK) begin
          ram_en_nxt    = 1'b0;
          ram_we_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_addr_nxt  = ram_addr;
          rsp_rdata_nxt = '0;
        end else if (!fifo_empty && (state == IDLE || ram_we)) begin
          pop           = 1'b1;
          ram_en_nxt    = 1'b1;
          ram_we_nxt    = (head_type == WRITE);
          ram_addr_nxt  = head_addr;
          ram_wdata_nxt = (head_type == WRITE) ? head_wdata : '0;
        end else begin
          ram_en_nxt = 1'b0;
          ram_we_nxt = 1'b0;
        end
      end
      RD_WAIT: begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = ram_rdata;
        rsp_addr_nxt  = ram_addr;
      end
      RESP:    if (rsp_ready) rsp_valid_nxt = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_ram_req_ctrl.sv
// Directed bench for block_ram_req_ctrl with a behavioural 256x16 RAM model.
module tb_block_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_type;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:255];

  block_ram_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  // Reset preloads mem[a] = 0xC000|a, except mem[0x20] = 0xAAAA.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
      mem[8'h20] <= 16'hAAAA;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic typ, input logic [7:0] addr, input logic [15:0] data);
    req_valid = 1'b1;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    int hits;
    rst = 1'b1; req_valid = 1'b0; req_type = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ram_en",    32'(ram_en),    32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    tick();

`ifndef BLOCK_RAM_WR_ACK_EN
    // Write 0x10=BEEF then read it back.
    rsp_ready = 1'b1;
    offer(1'b0, 8'h10, 16'hBEEF);
    tick();
    check("wr_idle_en", 32'(ram_en), 32'd0);
    offer(1'b1, 8'h10, 16'h0);
    tick();
    req_valid = 1'b0;
    check("wr_en",    32'(ram_en),    32'd1);
    check("wr_we",    32'(ram_we),    32'd1);
    check("wr_addr",  32'(ram_addr),  32'h10);
    check("wr_wdata", 32'(ram_wdata), 32'hBEEF);
    tick();
    check("rd_en",    32'(ram_en),    32'd1);
    check("rd_we",    32'(ram_we),    32'd0);
    check("rd_wdata", 32'(ram_wdata), 32'd0);
    tick();
    check("rd_en_drop",  32'(ram_en),    32'd0);
    check("rd_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    check("rd_rsp_addr",  32'(rsp_addr),  32'h10);
    tick();
    check("rd_rsp_clear", 32'(rsp_valid), 32'd0);
    tick();

    // Four back-to-back writes.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) offer(1'b0, 8'(k), 16'h0100 + 16'(k));
      else       req_valid = 1'b0;
      tick();
      if (k >= 1 && k <= 4) begin
        check($sformatf("b2b_en%0d", k-1),   32'(ram_en),    32'd1);
        check($sformatf("b2b_we%0d", k-1),   32'(ram_we),    32'd1);
        check($sformatf("b2b_addr%0d", k-1), 32'(ram_addr),  32'(k-1));
        check($sformatf("b2b_data%0d", k-1), 32'(ram_wdata), 32'h100 + 32'(k-1));
      end
      if (k == 5) check("b2b_end_en", 32'(ram_en), 32'd0);
    end
    tick();

    // Read 0x20 then write 0x20: write must wait for the read handshake.
    rsp_ready = 1'b0;
    offer(1'b1, 8'h20, 16'h0);
    tick();
    offer(1'b0, 8'h20, 16'h1234);
    tick();
    req_valid = 1'b0;
    check("raw_rd_en", 32'(ram_en), 32'd1);
    check("raw_rd_we", 32'(ram_we), 32'd0);
    tick();
    tick();
    check("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("raw_rsp_rdata", 32'(rsp_rdata), 32'hAAAA);
    tick();
    check("raw_hold_en",   32'(ram_en),    32'd0);
    check("raw_hold_rsp",  32'(rsp_rdata), 32'hAAAA);
    tick();
    check("raw_hold_en2",  32'(ram_en),    32'd0);
    check("raw_mem_old",   32'(mem[8'h20]), 32'hAAAA);
    rsp_ready = 1'b1;
    tick();
    check("raw_hs_valid",  32'(rsp_valid), 32'd0);
    check("raw_hs_en",     32'(ram_en),    32'd0);
    tick();
    check("raw_wr_en",    32'(ram_en),    32'd1);
    check("raw_wr_we",    32'(ram_we),    32'd1);
    check("raw_wr_wdata", 32'(ram_wdata), 32'h1234);
    tick();
    check("raw_wr_done",  32'(ram_en),      32'd0);
    check("raw_mem_new",  32'(mem[8'h20]),  32'h1234);
    tick();
`else
    // Write with acknowledge.
    rsp_ready = 1'b0;
    offer(1'b0, 8'h05, 16'h7777);
    tick();
    req_valid = 1'b0;
    tick();
    check("ack_wr_en", 32'(ram_en), 32'd1);
    check("ack_wr_we", 32'(ram_we), 32'd1);
    tick();
    check("ack_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ack_rsp_addr",  32'(rsp_addr),  32'h05);
    check("ack_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("ack_en_drop",   32'(ram_en),    32'd0);
    check("ack_mem",       32'(mem[8'h05]), 32'h7777);
    rsp_ready = 1'b1;
    tick();
    check("ack_rsp_clear", 32'(rsp_valid), 32'd0);
    tick();
`endif

    // Backpressure: five reads fill RESP plus the queue; the sixth is refused.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 8'h40 + 8'(i), 16'h5555);
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd1);
      tick();
    end
    offer(1'b1, 8'h45, 16'h5555);
    check("bp_full_ready0", 32'(req_ready), 32'd0);
    tick();
    check("bp_full_ready1", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_addr",  32'(rsp_addr),  32'h40);
    rsp_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      waited = 0;
      while (!rsp_valid && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("bp_wait%0d", r),  32'(waited < 10), 32'd1);
      check($sformatf("bp_addr%0d", r),  32'(rsp_addr),    32'h40 + 32'(r));
      check($sformatf("bp_rdata%0d", r), 32'(rsp_rdata),   32'hC040 + 32'(r));
      tick();
    end
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) hits++;
    end
    check("bp_no_extra_rsp", 32'(hits), 32'd0);

    // Reset while in RESP with two reads queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 8'h50 + 8'(i), 16'h0);
      tick();
    end
    req_valid = 1'b0;
    tick();
    check("mr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mr_rsp_addr",  32'(rsp_addr),  32'h50);
    rst = 1'b1;
    tick();
    check("mr_rsp_cleared", 32'(rsp_valid), 32'd0);
    check("mr_en_cleared",  32'(ram_en),    32'd0);
    check("mr_ready_low",   32'(req_ready), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mr_ready_high", 32'(req_ready), 32'd1);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ram_en || rsp_valid) hits++;
    end
    check("mr_no_activity", 32'(hits), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
